// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the nibble-FIFO UART transmitter.
// Contents: state_t FSM encoding, frame constants, even-parity helper.
// Build option: FIFO_UART_TX_PARITY_EN selects the PARITY state in the top.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        START   = 3'd2,
        DATA    = 3'd3,
        PARITY  = 3'd4,
        STOP    = 3'd5
    } state_t;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        TX_IDLE         = 1'b1;
    localparam logic        TX_START        = 1'b0;

    // Even parity: set when the data byte holds an odd number of ones.
    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_clear         restart the period at 0 (state change)
//   o_bit_end_c     last cycle of the current bit period
//   o_near_end_c    second-to-last cycle of the current bit period
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_bit_end_c,
    output logic o_near_end_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_end_c  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_near_end_c = (r_cnt == CNT_W'(CLKS_PER_BIT - 2));

    // Free-running 0..CLKS_PER_BIT-1, re-phased by every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_bit_end_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Read-side consumer of the nibble FIFO: pops low then high nibble,
// packs them into a byte and sends it as a UART frame (8N1, or 8E1).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   fifo_empty   FIFO empty flag (show-ahead read port)
//   fifo_rdata   FIFO head data
//   fifo_rinc    registered one-cycle pop strobe
//   flush        send a pending low nibble with a zero high nibble
//   tx           UART line, idle high, registered
//   busy         high whenever the FSM is not IDLE, registered
//   frame_done   one-cycle pulse in the final stop-bit cycle
// Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit.
module fifo_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned NIB_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [NIB_W-1:0] fifo_rdata,
    output logic             fifo_rinc,
    input  logic             flush,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BYTE_W = 2 * NIB_W;
    localparam int unsigned IDX_W  = $clog2(FRAME_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_DATA_BITS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [NIB_W-1:0]   r_lo;
    logic [NIB_W-1:0]   r_hi;
    logic [NIB_W-1:0]   w_lo_next;
    logic [NIB_W-1:0]   w_hi_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               r_tx;
    logic               r_busy;
    logic               r_rinc;
    logic               r_frame_done;
    logic               w_tx_next;
    logic               w_busy_next;
    logic               w_rinc_next;
    logic               w_frame_done_next;
    logic               w_bit_end;
    logic               w_near_end;
    logic               w_state_change;
    logic [BYTE_W-1:0]  w_byte;

    assign fifo_rinc  = r_rinc;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    assign w_byte         = {r_hi, r_lo};
    assign w_state_change = (w_state_next != r_state);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_state_change),
        .o_bit_end_c  (w_bit_end),
        .o_near_end_c (w_near_end)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_idx        <= '0;
            r_tx         <= TX_IDLE;
            r_busy       <= 1'b0;
            r_rinc       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_lo         <= w_lo_next;
            r_hi         <= w_hi_next;
            r_idx        <= w_idx_next;
            r_tx         <= w_tx_next;
            r_busy       <= w_busy_next;
            r_rinc       <= w_rinc_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // registered tx/busy line up with the state they describe.
    always_comb begin
        w_state_next = r_state;
        w_lo_next    = r_lo;
        w_hi_next    = r_hi;
        w_idx_next   = r_idx;
        w_rinc_next  = 1'b0;

        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_lo_next    = fifo_rdata;
                    w_rinc_next  = 1'b1;
                    w_state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                // fifo_rinc is high only in the first WAIT_HI cycle, while the
                // low-nibble pop has not yet reached the FIFO flags.
                if (!r_rinc) begin
                    if (!fifo_empty) begin
                        w_hi_next    = fifo_rdata;
                        w_rinc_next  = 1'b1;
                        w_state_next = START;
                    end else if (flush) begin
                        w_hi_next    = '0;
                        w_state_next = START;
                    end
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_idx_next = r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level, busy flag and end-of-frame pulse for the coming cycle.
    always_comb begin
        w_tx_next         = TX_IDLE;
        w_busy_next       = (w_state_next != IDLE);
        w_frame_done_next = (r_state == STOP) && w_near_end;

        case (w_state_next)
            START:   w_tx_next = TX_START;
            DATA:    w_tx_next = w_byte[w_idx_next];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  w_tx_next = even_parity(FRAME_DATA_BITS'(w_byte));
`endif
            default: w_tx_next = TX_IDLE;
        endcase
    end

endmodule
